// File: rtl/cpu_ctrl_alu.sv
// cpu_ctrl_alu: control FSM, 32-bit ALU and PC adder of the multi-cycle CPU.
// Every instruction walks FETCH -> DECODE -> EXECUTE -> WRITEBACK.
// Datapath selects and alu_op are pure opcode decode. Write/load enables are
// Moore outputs of state plus opcode. They are forced low while rst is low.
// Optional feature macro: ALU_SHIFT_EN. When it is defined, ALU ops 5/6/7 are
// real shifts. When it is undefined, those ops return 0 and no shifter is built.
module cpu_ctrl_alu (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  opcode,
    input  logic        eq,
    input  logic [31:0] alu_a,
    input  logic [31:0] alu_b,
    input  logic [31:0] add_a,
    input  logic [31:0] add_b,
    output logic [31:0] alu_y,
    output logic [31:0] add_y,
    output logic [1:0]  state,
    output logic [3:0]  alu_op,
    output logic        m13,
    output logic        m2,
    output logic        m457,
    output logic        m6,
    output logic        pc_flag,
    output logic        instruction_flag,
    output logic        change_address_flag,
    output logic        wr_en,
    output logic        wr_en_rf
);

    // Instruction opcodes, taken from instruction[31:28].
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_SLL  = 4'h5;
    localparam logic [3:0] OP_SRL  = 4'h6;
    localparam logic [3:0] OP_SRA  = 4'h7;
    localparam logic [3:0] OP_ADDI = 4'h8;
    localparam logic [3:0] OP_ORI  = 4'h9;
    localparam logic [3:0] OP_LUI  = 4'hA;
    localparam logic [3:0] OP_LW   = 4'hB;
    localparam logic [3:0] OP_SW   = 4'hC;
    localparam logic [3:0] OP_BEQ  = 4'hD;
    localparam logic [3:0] OP_BNE  = 4'hE;
    localparam logic [3:0] OP_JAL  = 4'hF;

    // ALU operation codes.
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SLL = 4'd5;
    localparam logic [3:0] ALU_SRL = 4'd6;
    localparam logic [3:0] ALU_SRA = 4'd7;
    localparam logic [3:0] ALU_LUI = 4'd8;
    localparam logic [3:0] ALU_SLT = 4'd9;

    typedef enum logic [1:0] {
        FETCH     = 2'd0,
        DECODE    = 2'd1,
        EXECUTE   = 2'd2,
        WRITEBACK = 2'd3
    } state_t;

    state_t cur_state;
    state_t next_state;

    assign state = cur_state;

    // PC adder: plain modulo-2^32 add with no carry out.
    assign add_y = add_a + add_b;

    // Decode the opcode into the ALU operation. This is independent of state.
    always_comb begin
        alu_op = ALU_ADD;
        case (opcode)
            OP_ADD:  alu_op = ALU_ADD;
            OP_SUB:  alu_op = ALU_SUB;
            OP_AND:  alu_op = ALU_AND;
            OP_OR:   alu_op = ALU_OR;
            OP_XOR:  alu_op = ALU_XOR;
            OP_SLL:  alu_op = ALU_SLL;
            OP_SRL:  alu_op = ALU_SRL;
            OP_SRA:  alu_op = ALU_SRA;
            OP_ADDI: alu_op = ALU_ADD;
            OP_ORI:  alu_op = ALU_OR;
            OP_LUI:  alu_op = ALU_LUI;
            default: alu_op = ALU_ADD;
        endcase
    end

    // ALU on the decoded operation. Results wrap, and no flags are produced.
    always_comb begin
        alu_y = 32'd0;
        case (alu_op)
            ALU_ADD: alu_y = alu_a + alu_b;
            ALU_SUB: alu_y = alu_a - alu_b;
            ALU_AND: alu_y = alu_a & alu_b;
            ALU_OR:  alu_y = alu_a | alu_b;
            ALU_XOR: alu_y = alu_a ^ alu_b;
`ifdef ALU_SHIFT_EN
            ALU_SLL: alu_y = alu_a << alu_b[4:0];
            ALU_SRL: alu_y = alu_a >> alu_b[4:0];
            ALU_SRA: alu_y = $unsigned($signed(alu_a) >>> alu_b[4:0]);
`else
            ALU_SLL: alu_y = 32'd0;
            ALU_SRL: alu_y = 32'd0;
            ALU_SRA: alu_y = 32'd0;
`endif
            ALU_LUI: alu_y = {alu_b[15:0], 16'd0};
            ALU_SLT: alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
            default: alu_y = 32'd0;
        endcase
    end

    // Datapath mux selects. These are valid in every state, including reset.
    // The values decoded during FETCH are unused.
    always_comb begin
        m457 = (opcode <= OP_LUI);
        m6   = (opcode >= OP_ADDI) && (opcode <= OP_LUI);
        m13  = (opcode == OP_JAL);
        m2   = ((opcode == OP_BEQ) && eq) || ((opcode == OP_BNE) && !eq);
    end

    // State register: a synchronous active-low reset returns the FSM to FETCH.
    always_ff @(posedge clk) begin
        if (!rst)
            cur_state <= FETCH;
        else
            cur_state <= next_state;
    end

    // Next state and Moore enables. The ring is unconditional, and reset masks
    // every enable combinationally so that a store stops at once.
    always_comb begin
        next_state          = cur_state;
        pc_flag             = 1'b0;
        instruction_flag    = 1'b0;
        change_address_flag = 1'b0;
        wr_en               = 1'b0;
        wr_en_rf            = 1'b0;
        case (cur_state)
            FETCH: begin
                next_state       = DECODE;
                instruction_flag = 1'b1;
            end
            DECODE: begin
                next_state = EXECUTE;
            end
            EXECUTE: begin
                next_state          = WRITEBACK;
                change_address_flag = (opcode == OP_LW) || (opcode == OP_SW);
                wr_en               = (opcode == OP_SW);
            end
            WRITEBACK: begin
                next_state          = FETCH;
                pc_flag             = 1'b1;
                wr_en_rf            = (opcode <= OP_LW) || (opcode == OP_JAL);
                change_address_flag = (opcode == OP_LW);
            end
            default: next_state = FETCH;
        endcase
        if (!rst) begin
            pc_flag             = 1'b0;
            instruction_flag    = 1'b0;
            change_address_flag = 1'b0;
            wr_en               = 1'b0;
            wr_en_rf            = 1'b0;
        end
    end

endmodule

// File: tb/tb_cpu_ctrl_alu.sv
// Self-checking bench for cpu_ctrl_alu. Each cycle pushes a reference
// expectation to a scoreboard queue and compares it at the falling edge.
module tb_cpu_ctrl_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  opcode;
    logic        eq;
    logic [31:0] alu_a, alu_b, add_a, add_b;
    logic [31:0] alu_y, add_y;
    logic [1:0]  state;
    logic [3:0]  alu_op;
    logic        m13, m2, m457, m6;
    logic        pc_flag, instruction_flag, change_address_flag, wr_en, wr_en_rf;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  st;
        logic [31:0] alu_y;
        logic [31:0] add_y;
        logic [3:0]  alu_op;
        logic [3:0]  sel;   // {m13, m2, m457, m6}
        logic [4:0]  en;    // {pc, instr, chg_addr, wr_en, wr_en_rf}
    } exp_t;

    exp_t sb[$];
    logic [1:0] ms;         // reference FSM state

    cpu_ctrl_alu dut (
        .clk(clk), .rst(rst), .opcode(opcode), .eq(eq),
        .alu_a(alu_a), .alu_b(alu_b), .add_a(add_a), .add_b(add_b),
        .alu_y(alu_y), .add_y(add_y), .state(state), .alu_op(alu_op),
        .m13(m13), .m2(m2), .m457(m457), .m6(m6),
        .pc_flag(pc_flag), .instruction_flag(instruction_flag),
        .change_address_flag(change_address_flag),
        .wr_en(wr_en), .wr_en_rf(wr_en_rf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] ref_op(input logic [3:0] op);
        if (op <= 4'h7)       return op;
        else if (op == 4'h9)  return 4'd3;
        else if (op == 4'hA)  return 4'd8;
        else                  return 4'd0;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic sh;
`ifdef ALU_SHIFT_EN
        sh = 1'b1;
`else
        sh = 1'b0;
`endif
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return sh ? a << b[4:0] : 32'd0;
            4'd6: return sh ? a >> b[4:0] : 32'd0;
            4'd7: return sh ? $unsigned($signed(a) >>> b[4:0]) : 32'd0;
            4'd8: return b << 16;
            4'd9: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [4:0] ref_en(input logic [1:0] s, input logic [3:0] op, input logic r);
        logic [4:0] e;
        e = 5'b0;
        if (r) begin
            case (s)
                2'd0: e[3] = 1'b1;
                2'd2: begin
                    e[2] = (op == 4'hB) || (op == 4'hC);
                    e[1] = (op == 4'hC);
                end
                2'd3: begin
                    e[4] = 1'b1;
                    e[2] = (op == 4'hB);
                    e[0] = (op <= 4'hB) || (op == 4'hF);
                end
                default: e = 5'b0;
            endcase
        end
        return e;
    endfunction

    // Run one clock: drive, push the expectation, compare at negedge, and advance the model.
    task automatic step(input logic r, input logic [3:0] op, input logic e,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pa, input logic [31:0] pb);
        exp_t x, y;
        rst = r; opcode = op; eq = e;
        alu_a = a; alu_b = b; add_a = pa; add_b = pb;
        x.st     = ms;
        x.alu_op = ref_op(op);
        x.alu_y  = ref_alu(x.alu_op, a, b);
        x.add_y  = pa + pb;
        x.sel    = {op == 4'hF, (op == 4'hD && e) || (op == 4'hE && !e),
                    op <= 4'hA, op >= 4'h8 && op <= 4'hA};
        x.en     = ref_en(ms, op, r);
        sb.push_back(x);
        @(negedge clk);
        y = sb.pop_front();
        chk($sformatf("state op%h", op), {30'd0, state}, {30'd0, y.st});
        chk($sformatf("alu_op op%h", op), {28'd0, alu_op}, {28'd0, y.alu_op});
        chk($sformatf("alu_y op%h", op), alu_y, y.alu_y);
        chk($sformatf("add_y op%h", op), add_y, y.add_y);
        chk($sformatf("sel op%h st%0d", op, y.st), {28'd0, m13, m2, m457, m6}, {28'd0, y.sel});
        chk($sformatf("en op%h st%0d", op, y.st),
            {27'd0, pc_flag, instruction_flag, change_address_flag, wr_en, wr_en_rf}, {27'd0, y.en});
        @(posedge clk);
        ms = r ? ms + 2'd1 : 2'd0;
        #1;
    endtask

    task automatic run_instr(input logic [3:0] op, input logic e,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] pa, input logic [31:0] pb);
        for (int i = 0; i < 4; i++) step(1'b1, op, e, a, b, pa, pb);
    endtask

    initial begin
        rst = 1'b0; opcode = 4'h0; eq = 1'b0;
        alu_a = '0; alu_b = '0; add_a = '0; add_b = '0;
        @(posedge clk);
        ms = 2'd0;
        #1;
        // held reset: state 0, enables 0
        step(1'b0, 4'h0, 1'b0, 32'h1, 32'h2, 32'h0, 32'h4);
        step(1'b0, 4'hC, 1'b0, 32'h1, 32'h2, 32'h0, 32'h4);
        // ALU sweep
        run_instr(4'h0, 1'b0, 32'hFFFFFFFF, 32'h1, 32'h100, 32'h4);
        run_instr(4'h1, 1'b0, 32'hFFFFFFFF, 32'h1, 32'h104, 32'h4);
        run_instr(4'h7, 1'b0, 32'h80000000, 32'h4, 32'h108, 32'h4);
        run_instr(4'h6, 1'b0, 32'h80000000, 32'h4, 32'h10C, 32'h4);
        run_instr(4'h5, 1'b0, 32'h00000003, 32'h1F, 32'h110, 32'h4);
        run_instr(4'hA, 1'b0, 32'h0, 32'h1234, 32'h114, 32'h4);
        for (int k = 2; k <= 4; k++)
            run_instr(4'(k), 1'b0, $urandom, $urandom, $urandom, 32'h4);
        run_instr(4'h8, 1'b0, 32'h7FFFFFFF, 32'h1, 32'h118, 32'h4);
        run_instr(4'h9, 1'b0, 32'hF0F00000, 32'h0000ABCD, 32'h11C, 32'h4);
        // branches
        run_instr(4'hD, 1'b1, 32'h5, 32'h5, 32'h200, 32'h40);
        run_instr(4'hD, 1'b0, 32'h5, 32'h6, 32'h200, 32'h4);
        run_instr(4'hE, 1'b1, 32'h5, 32'h5, 32'h200, 32'h4);
        run_instr(4'hE, 1'b0, 32'h5, 32'h6, 32'h200, 32'hFFFFFFF0);
        // memory ops and JAL
        run_instr(4'hC, 1'b0, 32'h10, 32'h20, 32'h300, 32'h4);
        run_instr(4'hB, 1'b0, 32'h10, 32'h20, 32'h304, 32'h4);
        run_instr(4'hF, 1'b1, 32'h1, 32'h2, 32'hFFFFFFFC, 32'h4);
        // reset in EXECUTE of SW: enables drop now, FETCH at next edge
        step(1'b1, 4'hC, 1'b0, 32'h0, 32'h0, 32'h400, 32'h4);
        step(1'b1, 4'hC, 1'b0, 32'h0, 32'h0, 32'h400, 32'h4);
        step(1'b0, 4'hC, 1'b0, 32'h0, 32'h0, 32'h400, 32'h4);
        run_instr(4'h0, 1'b0, 32'h3, 32'h4, 32'h404, 32'h4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
